// File: rtl/adbg_pkg.sv
// Shared constants and types for the debug-unit top-level module select chain.
package adbg_pkg;

  // Largest number of debug modules the top-level chain can address.
  localparam int unsigned DBG_TOP_MAX_MODULES = 16;

  // Well-known module IDs on the top-level chain.
  localparam int unsigned DBG_TOP_BUSIF_DEBUG_MODULE    = 0;
  localparam int unsigned DBG_TOP_CPU_DEBUG_MODULE      = 1;
  localparam int unsigned DBG_TOP_JSP_DEBUG_MODULE      = 2;
  localparam int unsigned DBG_TOP_RESERVED_DEBUG_MODULE = 3;

  // Scan state of the select chain.
  typedef enum logic [1:0] {
    StIdle,
    StCaptured,
    StShifting
  } sel_state_e;

endpackage

// File: rtl/adbg_module_select.sv
// Top-level debug module select: decodes a select command scanned in through the DEBUG
// data register, keeps the one-hot module selection and routes the selected module's
// serial output (or a status word) to tdo_o.
module adbg_module_select
  import adbg_pkg::*;
#(
  parameter int unsigned              NUM_MODULES      = 4,
  parameter int unsigned              MODULE_ID_LENGTH = $clog2(NUM_MODULES),
  parameter logic [NUM_MODULES-1:0]   MODULE_ENABLE    = '1
) (
  input  logic                        tck_i,
  input  logic                        tlr_i,
  input  logic                        debug_select_i,
  input  logic                        capture_dr_i,
  input  logic                        shift_dr_i,
  input  logic                        update_dr_i,
  input  logic                        tdi_i,
  output logic                        tdo_o,
  input  logic [NUM_MODULES-1:0]      module_tdo_i,
  output logic [NUM_MODULES-1:0]      module_select_o,
  output logic [MODULE_ID_LENGTH-1:0] module_id_o,
  output logic                        select_error_o
);

  // Command is a select flag (MSB) followed by the module ID.
  localparam int unsigned CmdW = 1 + MODULE_ID_LENGTH;
  localparam int unsigned CntW = $clog2(CmdW + 1);
  localparam logic [CntW-1:0] CntFull = CntW'(CmdW);

  sel_state_e                  state_q;
  logic [CmdW-1:0]             cmd_q;
  logic [CmdW-1:0]             status_q;
  logic [CntW-1:0]             cnt_q;
  logic [NUM_MODULES-1:0]      sel_q;
  logic [MODULE_ID_LENGTH-1:0] id_q;
  logic                        err_q;

  // Strobes qualified by the DEBUG instruction, highest priority first.
  logic upd_s, cap_s, sh_s;
  assign upd_s = debug_select_i & update_dr_i;
  assign cap_s = debug_select_i & capture_dr_i & ~update_dr_i;
  assign sh_s  = debug_select_i & shift_dr_i & ~capture_dr_i & ~update_dr_i;

  logic [MODULE_ID_LENGTH-1:0] cmd_id;
  logic                        id_valid;
  logic [NUM_MODULES-1:0]      id_onehot;
  logic                        cmd_complete;

  assign cmd_id       = cmd_q[MODULE_ID_LENGTH-1:0];
  assign cmd_complete = (state_q != StIdle) && (cnt_q == CntFull);

  // Decode the scanned ID against the implemented and enabled modules.
  always_comb begin
    id_valid = 1'b0;
    for (int unsigned i = 0; i < NUM_MODULES; i++) begin
      if (cmd_id == MODULE_ID_LENGTH'(i) && MODULE_ENABLE[i]) begin
        id_valid = 1'b1;
      end
    end
    id_onehot = id_valid ? (NUM_MODULES'(1) << cmd_id) : '0;
  end

  // Scan FSM with registered selection outputs.
  always_ff @(posedge tck_i) begin
    if (tlr_i) begin
      state_q  <= StIdle;
      cmd_q    <= '0;
      status_q <= '0;
      cnt_q    <= '0;
      sel_q    <= '0;
      id_q     <= '0;
      err_q    <= 1'b0;
    end else if (upd_s) begin
      // A short scan or an update without capture is dropped; MSB=0 targets a module.
      if (cmd_complete && cmd_q[CmdW-1]) begin
        if (id_valid) begin
          sel_q <= id_onehot;
          id_q  <= cmd_id;
          err_q <= 1'b0;
        end else begin
          sel_q <= '0;
          err_q <= 1'b1;
        end
      end
      state_q <= StIdle;
    end else if (cap_s) begin
      state_q  <= StCaptured;
      cmd_q    <= '0;
      cnt_q    <= '0;
      status_q <= {err_q, id_q};
    end else if (sh_s && state_q != StIdle) begin
      state_q  <= StShifting;
      cmd_q    <= {tdi_i, cmd_q[CmdW-1:1]};
      status_q <= {1'b0, status_q[CmdW-1:1]};
      if (cnt_q != CntFull) begin
        cnt_q <= cnt_q + CntW'(1);
      end
    end
  end

  // Selected module drives tdo; otherwise the status word is shifted out.
  always_comb begin
    tdo_o = status_q[0];
    if (|sel_q) begin
      tdo_o = module_tdo_i[id_q];
    end
  end

  assign module_select_o = sel_q;
  assign module_id_o     = id_q;
  assign select_error_o  = err_q;

endmodule

// File: tb/tb_adbg_module_select.sv
// Bench for adbg_module_select: directed scenarios followed by random strobe traffic, all
// checked against a queue-based model of the select chain.
module tb_adbg_module_select;

  localparam int unsigned N   = 4;
  localparam int unsigned IDL = 2;
  localparam int unsigned W   = 1 + IDL;
  localparam logic [N-1:0] En = 4'b0111;

  logic           tck = 1'b0;
  logic           tlr = 1'b0;
  logic           dbg = 1'b0;
  logic           cap = 1'b0;
  logic           sh  = 1'b0;
  logic           upd = 1'b0;
  logic           tdi = 1'b0;
  logic           tdo;
  logic [N-1:0]   mtdo = '0;
  logic [N-1:0]   msel;
  logic [IDL-1:0] mid;
  logic           merr;

  int checks   = 0;
  int failures = 0;

  adbg_module_select #(
    .NUM_MODULES      (N),
    .MODULE_ID_LENGTH (IDL),
    .MODULE_ENABLE    (En)
  ) dut (
    .tck_i           (tck),
    .tlr_i           (tlr),
    .debug_select_i  (dbg),
    .capture_dr_i    (cap),
    .shift_dr_i      (sh),
    .update_dr_i     (upd),
    .tdi_i           (tdi),
    .tdo_o           (tdo),
    .module_tdo_i    (mtdo),
    .module_select_o (msel),
    .module_id_o     (mid),
    .select_error_o  (merr)
  );

  always #5 tck = ~tck;

  // Reference model: "armed" means a capture happened since the last update/reset;
  // cmd_bits holds the last W scanned bits (oldest first); status_bits is what remains
  // of the captured status word, LSB first.
  bit armed = 1'b0;
  int cnt   = 0;
  bit cmd_bits[$];
  bit status_bits[$];
  int m_sel = 0;
  int m_id  = 0;
  int m_err = 0;

  function automatic void model_step();
    int id;
    if (tlr) begin
      armed = 0; cnt = 0; cmd_bits.delete(); status_bits.delete();
      for (int i = 0; i < W; i++) cmd_bits.push_back(1'b0);
      m_sel = 0; m_id = 0; m_err = 0;
    end else if (dbg && upd) begin
      if (armed && cnt == W && cmd_bits[W-1]) begin
        id = 0;
        for (int i = 0; i < W - 1; i++) id += int'(cmd_bits[i]) * (1 << i);
        if (id < N && En[id]) begin
          m_sel = 1 << id; m_id = id; m_err = 0;
        end else begin
          m_sel = 0; m_err = 1;
        end
      end
      armed = 0;
    end else if (dbg && cap) begin
      armed = 1; cnt = 0; cmd_bits.delete(); status_bits.delete();
      for (int i = 0; i < W; i++) cmd_bits.push_back(1'b0);
      for (int i = 0; i < IDL; i++) status_bits.push_back(bit'((m_id >> i) & 1));
      status_bits.push_back(bit'(m_err));
    end else if (dbg && sh && armed) begin
      cmd_bits.push_back(tdi);
      void'(cmd_bits.pop_front());
      if (cnt < W) cnt++;
      if (status_bits.size() > 0) void'(status_bits.pop_front());
    end
  endfunction

  function automatic int exp_tdo();
    if (m_sel != 0) return int'(mtdo[m_id]);
    if (status_bits.size() > 0) return int'(status_bits[0]);
    return 0;
  endfunction

  task automatic chk(input string tag, input int obs, input int expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, "_sel"}, int'(msel), m_sel);
    chk({tag, "_id"},  int'(mid),  m_id);
    chk({tag, "_err"}, int'(merr), m_err);
    chk({tag, "_tdo"}, int'(tdo),  exp_tdo());
  endtask

  task automatic tick(input string tag);
    @(posedge tck);
    model_step();
    #1;
    check_all(tag);
  endtask

  task automatic strobe(input logic c, input logic s, input logic u, input logic d,
                        input string tag);
    cap = c; sh = s; upd = u; tdi = d;
    tick(tag);
    cap = 1'b0; sh = 1'b0; upd = 1'b0;
  endtask

  // Full DR scan: capture, n shift bits of data LSB first, update.
  task automatic scan(input int n, input logic [31:0] data, input string tag);
    logic [31:0] d;
    d = data;
    strobe(1'b1, 1'b0, 1'b0, 1'b0, {tag, "_cap"});
    for (int i = 0; i < n; i++) begin
      mtdo = N'($urandom);
      strobe(1'b0, 1'b1, 1'b0, d[i], {tag, "_sh"});
    end
    strobe(1'b0, 1'b0, 1'b1, 1'b0, {tag, "_upd"});
  endtask

  initial begin
    // Reset.
    tlr = 1'b1; dbg = 1'b1;
    tick("reset");
    tlr = 1'b0;
    chk("reset_sel_const", int'(msel), 0);

    // Select module 2 with bits 0,1,1.
    scan(3, 32'b110, "sel2");
    chk("sel2_onehot", int'(msel), 4'b0100);
    chk("sel2_id", int'(mid), 2);

    // 16-bit module scan with final bit 0: selection holds, tdo follows module 2.
    scan(16, 32'h0000_7fff, "modcmd");
    chk("modcmd_hold", int'(msel), 4'b0100);

    // DEBUG not selected: select ID 1 ignored, then taken.
    dbg = 1'b0;
    scan(3, 32'b101, "nodbg");
    chk("nodbg_hold", int'(msel), 4'b0100);
    dbg = 1'b1;
    scan(3, 32'b101, "dbg1");
    chk("dbg1_onehot", int'(msel), 4'b0010);

    // Disabled ID 3: error set, id kept at 1, status shifts out 1 (id LSB) first.
    scan(3, 32'b111, "dis3");
    chk("dis3_err", int'(merr), 1);
    chk("dis3_sel", int'(msel), 0);
    strobe(1'b1, 1'b0, 1'b0, 1'b0, "stat_cap");
    chk("stat_first_bit", int'(tdo), 1);
    for (int i = 0; i < 4; i++) strobe(1'b0, 1'b1, 1'b0, 1'b1, "stat_sh");
    strobe(1'b0, 1'b0, 1'b1, 1'b0, "stat_upd");

    // Short scan is discarded.
    scan(2, 32'b11, "short");
    chk("short_err", int'(merr), 1);

    // Reset mid-scan, then an update without capture is ignored.
    strobe(1'b1, 1'b0, 1'b0, 1'b0, "abort_cap");
    strobe(1'b0, 1'b1, 1'b0, 1'b0, "abort_sh");
    tlr = 1'b1;
    tick("abort_tlr");
    tlr = 1'b0;
    strobe(1'b0, 1'b1, 1'b0, 1'b1, "abort_sh2");
    strobe(1'b0, 1'b0, 1'b1, 1'b0, "abort_upd");
    chk("abort_sel", int'(msel), 0);
    chk("abort_err", int'(merr), 0);

    // Random traffic, including overlapping strobes.
    for (int c = 0; c < 4000; c++) begin
      tlr  = ($urandom_range(0, 99) < 2);
      dbg  = ($urandom_range(0, 9) != 0);
      cap  = ($urandom_range(0, 7) == 0);
      upd  = ($urandom_range(0, 7) == 0);
      sh   = ($urandom_range(0, 2) != 0);
      tdi  = 1'($urandom);
      mtdo = N'($urandom);
      tick("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
